// File: rtl/flow_req_pkg.sv
// rtl/flow_req_pkg.sv - shared constants, header byte offsets and FSM states for flow_req_gen
package flow_req_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP     = 8'd6;
  localparam logic [7:0]  PROTO_UDP     = 8'd17;

  // Byte offsets within beat 0 (Ethernet + IPv4 header start)
  localparam int OFF_ETYPE = 12;
  localparam int OFF_PROTO = 23;
  localparam int OFF_SIP   = 26;
  localparam int OFF_DIP0  = 30;   // upper half of dst IP
  // Byte offsets within beat 1
  localparam int OFF_DIP1  = 0;    // lower half of dst IP
  localparam int OFF_SPORT = 2;
  localparam int OFF_DPORT = 4;

  // Request payload field positions
  localparam int LEN_LSB = 32;
  localparam int CNT_LSB = 48;

  // {sip, dip, proto, sport, dport}
  localparam int KEY_W = 104;

  typedef enum logic [1:0] {SOP, W1, SKIP} state_t;

endpackage

// File: rtl/flow_hash_fold.sv
// rtl/flow_hash_fold.sv - XOR-folds the 5-tuple key into a table address, one register stage
// Ports: clk, reset (sync, active-high); load_i captures fold of key_i; hash_o registered hash.
module flow_hash_fold
  import flow_req_pkg::*;
#(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [KEY_W-1:0]     key_i,
  output logic [ADDR_BITS-1:0] hash_o
);

  localparam int NCHUNK = (KEY_W + ADDR_BITS - 1) / ADDR_BITS;

  logic [NCHUNK*ADDR_BITS-1:0] padded;
  logic [ADDR_BITS-1:0]        hash_d;
  logic [ADDR_BITS-1:0]        hash_q;

  // Chunks are taken LSB-first; the topmost chunk is zero-padded.
  always_comb begin
    padded            = '0;
    padded[KEY_W-1:0] = key_i;
    hash_d            = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      hash_d = hash_d ^ padded[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_q <= '0;
    end else if (load_i) begin
      hash_q <= hash_d;
    end
  end

  assign hash_o = hash_q;

endmodule

// File: rtl/flow_req_gen.sv
// rtl/flow_req_gen.sv - stream tap that turns each packet into one paced flow-counter increment request
// Ports: clk/reset (sync, active-high); s_axis_* passive packet tap (tready tied high);
// enable gates counting at SOP; write_full backpressure; write_data/_addr/_valid request strobe;
// pkt_seen counted packets; drop_count requests lost to overload.
module flow_req_gen
  import flow_req_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TDATA_WIDTH          = 24,
  parameter int ADDR_BITS            = 11,
  parameter int MIN_GAP              = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            enable,
  input  logic                            write_full,
  output logic [8*TDATA_WIDTH+8:0]        write_data,
  output logic [31:0]                     write_data_addr,
  output logic                            write_data_valid,
  output logic [31:0]                     pkt_seen,
  output logic [31:0]                     drop_count
);

  localparam int GAP_W = $clog2(MIN_GAP);

  function automatic logic [7:0] get_byte(input logic [C_S_AXIS_DATA_WIDTH-1:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  state_t state_q, state_d;

  logic [15:0] etype_q, dip_hi_q, len_q;
  logic [7:0]  proto_q;
  logic [31:0] sip_q;

  logic             hdr_done;
  logic             req_q;
  logic [KEY_W-1:0] key;
  logic [15:0]      sport, dport;
  logic [ADDR_BITS-1:0] hash;

  logic                 pend_q;
  logic [ADDR_BITS-1:0] pend_addr_q;
  logic [15:0]          pend_len_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 emit;

  logic                 wdv_q;
  logic [ADDR_BITS-1:0] wd_addr_q;
  logic [15:0]          wd_len_q;
  logic                 wd_cnt_q;
  logic [31:0]          pkt_seen_q, drop_q;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tkeep, s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:16], s_axis_tdata};

  assign s_axis_tready = 1'b1;

  // Final header beat of a counted packet: a single-beat packet at SOP, or beat 1.
  // W1 is only reachable when enable was high at SOP.
  assign hdr_done = s_axis_tvalid &&
                    ((state_q == SOP && enable && s_axis_tlast) || state_q == W1);

  always_comb begin
    state_d = state_q;
    if (s_axis_tvalid) begin
      case (state_q)
        SOP:     state_d = s_axis_tlast ? SOP : (enable ? W1 : SKIP);
        W1:      state_d = s_axis_tlast ? SOP : SKIP;
        SKIP:    state_d = s_axis_tlast ? SOP : SKIP;
        default: state_d = SOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SOP;
      etype_q  <= '0;
      proto_q  <= '0;
      sip_q    <= '0;
      dip_hi_q <= '0;
      len_q    <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= hdr_done;
      if (s_axis_tvalid && state_q == SOP && enable) begin
        etype_q  <= {get_byte(s_axis_tdata, OFF_ETYPE), get_byte(s_axis_tdata, OFF_ETYPE+1)};
        proto_q  <= get_byte(s_axis_tdata, OFF_PROTO);
        sip_q    <= {get_byte(s_axis_tdata, OFF_SIP),   get_byte(s_axis_tdata, OFF_SIP+1),
                     get_byte(s_axis_tdata, OFF_SIP+2), get_byte(s_axis_tdata, OFF_SIP+3)};
        dip_hi_q <= {get_byte(s_axis_tdata, OFF_DIP0),  get_byte(s_axis_tdata, OFF_DIP0+1)};
        len_q    <= s_axis_tuser[15:0];
      end
    end
  end

  // Short packets and non-IPv4 hash a zero key, which folds to address 0.
  always_comb begin
    sport = '0;
    dport = '0;
    if (proto_q == PROTO_TCP || proto_q == PROTO_UDP) begin
      sport = {get_byte(s_axis_tdata, OFF_SPORT), get_byte(s_axis_tdata, OFF_SPORT+1)};
      dport = {get_byte(s_axis_tdata, OFF_DPORT), get_byte(s_axis_tdata, OFF_DPORT+1)};
    end
    key = '0;
    if (state_q == W1 && etype_q == ETH_TYPE_IPV4) begin
      key = {sip_q, dip_hi_q,
             get_byte(s_axis_tdata, OFF_DIP1), get_byte(s_axis_tdata, OFF_DIP1+1),
             proto_q, sport, dport};
    end
  end

  flow_hash_fold #(.ADDR_BITS(ADDR_BITS)) u_hash (
    .clk    (clk),
    .reset  (reset),
    .load_i (hdr_done),
    .key_i  (key),
    .hash_o (hash)
  );

  assign emit = pend_q && !write_full && (gap_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_len_q  <= '0;
      gap_q       <= '0;
      wdv_q       <= 1'b0;
      wd_addr_q   <= '0;
      wd_len_q    <= '0;
      wd_cnt_q    <= 1'b0;
      pkt_seen_q  <= '0;
      drop_q      <= '0;
    end else begin
      wdv_q <= emit;
      if (emit) begin
        wd_addr_q <= pend_addr_q;
        wd_len_q  <= pend_len_q;
        wd_cnt_q  <= 1'b1;
        gap_q     <= GAP_W'(MIN_GAP - 1);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
      // A request arriving while the slot drains this cycle takes the slot.
      if (req_q && (!pend_q || emit)) begin
        pend_q      <= 1'b1;
        pend_addr_q <= hash;
        pend_len_q  <= len_q;
      end else if (emit) begin
        pend_q <= 1'b0;
      end
      if (req_q && pend_q && !emit && drop_q != 32'hFFFF_FFFF) begin
        drop_q <= drop_q + 32'd1;
      end
      if (req_q && pkt_seen_q != 32'hFFFF_FFFF) begin
        pkt_seen_q <= pkt_seen_q + 32'd1;
      end
    end
  end

  always_comb begin
    write_data                   = '0;
    write_data[LEN_LSB +: 16]    = wd_len_q;
    write_data[CNT_LSB +: 16]    = {15'd0, wd_cnt_q};
  end

  assign write_data_addr  = {{(32-ADDR_BITS){1'b0}}, wd_addr_q};
  assign write_data_valid = wdv_q;
  assign pkt_seen         = pkt_seen_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_flow_req_gen.sv
// tb/tb_flow_req_gen.sv - scoreboard bench for flow_req_gen with randomized packets
module tb_flow_req_gen;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int TW = 24;
  localparam int AB = 11;
  localparam int MG = 4;
  localparam int RW = 8*TW + 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          enable, write_full;
  logic [RW-1:0] write_data;
  logic [31:0]   write_data_addr;
  logic          write_data_valid;
  logic [31:0]   pkt_seen, drop_count;

  always #5 clk = ~clk;

  flow_req_gen #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .TDATA_WIDTH(TW),
    .ADDR_BITS(AB), .MIN_GAP(MG)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .enable(enable), .write_full(write_full),
    .write_data(write_data), .write_data_addr(write_data_addr),
    .write_data_valid(write_data_valid),
    .pkt_seen(pkt_seen), .drop_count(drop_count)
  );

  typedef struct {
    int             edge_no;
    logic [AB-1:0]  addr;
    logic [15:0]    len;
  } req_t;

  req_t arrivals[$];
  req_t expq[$];

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  bit   m_pend = 0;
  req_t m_req;
  int   m_last_emit = -1000;
  int   exp_pkt = 0;
  int   exp_drop = 0;

  int            n_strobes = 0;
  int            last_strobe_edge = -1000;
  bit            had_strobe = 0;
  logic [AB-1:0] last_exp_addr;
  logic [15:0]   last_exp_len;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_wd(input logic [15:0] len);
    logic [RW-1:0] w;
    w = '0;
    w[47:32] = len;
    w[63:48] = 16'd1;
    return w;
  endfunction

  // Reference address: every key bit i is XORed into address bit (i mod AB).
  function automatic logic [AB-1:0] model_addr(input logic [15:0] etype, input logic [7:0] proto,
                                               input logic [31:0] sip, input logic [31:0] dip,
                                               input logic [15:0] sport, input logic [15:0] dport,
                                               input bit short_pkt);
    logic [103:0]  key;
    logic [AB-1:0] h;
    h = '0;
    if (short_pkt || etype != 16'h0800) return h;
    if (proto != 8'd6 && proto != 8'd17) begin
      sport = 16'd0;
      dport = 16'd0;
    end
    key = {sip, dip, proto, sport, dport};
    for (int i = 0; i < 104; i++) h[i % AB] = h[i % AB] ^ key[i];
    return h;
  endfunction

  // Pacing model: one-slot holding buffer, MIN_GAP spacing between emissions, write_full hold.
  initial begin
    bit   emit;
    req_t a;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        m_pend = 0;
        m_last_emit = -1000;
        arrivals.delete();
      end else begin
        emit = m_pend && !write_full && (edge_cnt - m_last_emit >= MG);
        if (emit) begin
          a = m_req;
          a.edge_no = edge_cnt;
          expq.push_back(a);
          m_last_emit = edge_cnt;
          m_pend = 0;
        end
        if (arrivals.size() > 0 && arrivals[0].edge_no == edge_cnt) begin
          a = arrivals.pop_front();
          exp_pkt++;
          if (m_pend) exp_drop++;
          else begin
            m_pend = 1;
            m_req = a;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write_data_valid) begin
          n_strobes++;
          checks++;
          if (edge_cnt - last_strobe_edge < MG) begin
            failures++;
            $display("FAIL strobe_gap actual=%0d required>=%0d", edge_cnt - last_strobe_edge, MG);
          end
          last_strobe_edge = edge_cnt;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=1 expected=0 at edge %0d", edge_cnt);
          end else begin
            e = expq.pop_front();
            check("strobe_edge", RW'(edge_cnt), RW'(e.edge_no));
            check("strobe_addr", RW'(write_data_addr), RW'({21'd0, e.addr}));
            check("strobe_data", write_data, exp_wd(e.len));
            last_exp_addr = e.addr;
            last_exp_len = e.len;
            had_strobe = 1;
          end
        end else if (had_strobe) begin
          check("hold_addr", RW'(write_data_addr), RW'({21'd0, last_exp_addr}));
          check("hold_data", write_data, exp_wd(last_exp_len));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [7:0] proto,
                          input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sport, input logic [15:0] dport,
                          input logic [15:0] len, input int nbeats,
                          input bit en_sop, input bit en_after);
    logic [DW-1:0] b0, b1, bx;
    req_t r;
    for (int i = 0; i < 8; i++) begin
      b0[32*i +: 32] = $urandom();
      b1[32*i +: 32] = $urandom();
    end
    b0[12*8 +: 8] = etype[15:8];  b0[13*8 +: 8] = etype[7:0];
    b0[23*8 +: 8] = proto;
    b0[26*8 +: 8] = sip[31:24];   b0[27*8 +: 8] = sip[23:16];
    b0[28*8 +: 8] = sip[15:8];    b0[29*8 +: 8] = sip[7:0];
    b0[30*8 +: 8] = dip[31:24];   b0[31*8 +: 8] = dip[23:16];
    b1[0 +: 8]    = dip[15:8];    b1[8 +: 8]    = dip[7:0];
    b1[16 +: 8]   = sport[15:8];  b1[24 +: 8]   = sport[7:0];
    b1[32 +: 8]   = dport[15:8];  b1[40 +: 8]   = dport[7:0];
    for (int beat = 0; beat < nbeats; beat++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) bx[32*i +: 32] = $urandom();
      s_axis_tdata  = (beat == 0) ? b0 : ((beat == 1) ? b1 : bx);
      s_axis_tuser  = {$urandom(), $urandom(), $urandom(), 16'($urandom()), len};
      s_axis_tkeep  = 32'hFFFF_FFFF;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (beat == nbeats - 1);
      enable        = (beat == 0) ? en_sop : en_after;
      if (en_sop && (beat == 1 || (nbeats == 1 && beat == 0))) begin
        r.edge_no = edge_cnt + 2;
        r.addr = model_addr(etype, proto, sip, dip, sport, dport, nbeats == 1);
        r.len = len;
        arrivals.push_back(r);
      end
    end
  endtask

  task automatic drain_and_check(input string name);
    idle(24);
    check({name, "_drain"}, RW'(expq.size()), RW'(0));
    check({name, "_pkt_seen"}, RW'(pkt_seen), RW'(exp_pkt));
    check({name, "_drop_count"}, RW'(drop_count), RW'(exp_drop));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
    exp_pkt = 0;
    exp_drop = 0;
    had_strobe = 0;
    last_strobe_edge = -1000;
  endtask

  initial begin
    int s0, d0, nb;
    logic [15:0] et;
    logic [7:0]  pr;
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    enable = 1'b0; write_full = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_tready", RW'(s_axis_tready), RW'(1));
    check("rst_valid", RW'(write_data_valid), RW'(0));
    check("rst_data", write_data, '0);
    check("rst_addr", RW'(write_data_addr), RW'(0));
    check("rst_pkt_seen", RW'(pkt_seen), RW'(0));
    check("rst_drop", RW'(drop_count), RW'(0));

    // TCP packet 10.0.0.1:80 -> 10.0.0.2:1234, len 64
    send_pkt(16'h0800, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd1234, 16'd64, 2, 1, 1);
    drain_and_check("tcp");
    check("tcp_pkt_seen_one", RW'(pkt_seen), RW'(1));
    check("tcp_addr_value", RW'(write_data_addr),
          RW'({21'd0, model_addr(16'h0800, 8'd6, 32'h0A00_0001, 32'h0A00_0002, 16'd80, 16'd1234, 0)}));
    check("tcp_wd_63_32", RW'(write_data[63:32]), RW'(32'h0001_0040));

    // ARP, two beats
    send_pkt(16'h0806, 8'd6, $urandom(), $urandom(), 16'd1, 16'd2, 16'd60, 2, 1, 1);
    drain_and_check("arp");
    check("arp_addr_zero", RW'(write_data_addr), RW'(0));
    check("arp_len", RW'(write_data[47:32]), RW'(16'd60));

    // Single-beat IPv4 packet
    s0 = n_strobes;
    send_pkt(16'h0800, 8'd17, $urandom(), $urandom(), 16'd5, 16'd6, 16'd40, 1, 1, 1);
    drain_and_check("short");
    check("short_addr_zero", RW'(write_data_addr), RW'(0));
    check("short_one_strobe", RW'(n_strobes - s0), RW'(1));

    // Backpressure across three back-to-back packets
    write_full = 1'b1;
    for (int k = 0; k < 3; k++)
      send_pkt(16'h0800, 8'd6, $urandom(), $urandom(), 16'($urandom()), 16'($urandom()),
               16'(100 + k), 2, 1, 1);
    idle(14);
    write_full = 1'b0;
    drain_and_check("full");

    // Eight back-to-back packets, no backpressure
    s0 = n_strobes;
    d0 = drop_count;
    for (int k = 0; k < 8; k++)
      send_pkt(16'h0800, 8'd17, $urandom(), $urandom(), 16'($urandom()), 16'($urandom()),
               16'(200 + k), 2, 1, 1);
    drain_and_check("burst8");
    check("burst8_total", RW'((n_strobes - s0) + (drop_count - d0)), RW'(8));

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      write_full = ($urandom_range(0, 3) == 0);
      nb = $urandom_range(1, 4);
      et = ($urandom_range(0, 4) == 0) ? 16'($urandom()) : 16'h0800;
      case ($urandom_range(0, 3))
        0: pr = 8'd6;
        1: pr = 8'd17;
        2: pr = 8'd1;
        default: pr = 8'($urandom());
      endcase
      send_pkt(et, pr, $urandom(), $urandom(), 16'($urandom()), 16'($urandom()),
               16'($urandom()), nb, $urandom_range(0, 4) != 0, 1);
      idle($urandom_range(0, 3));
    end
    write_full = 1'b0;
    drain_and_check("random");

    // Enable raised mid-packet: A ignored, B counted
    do_reset();
    send_pkt(16'h0800, 8'd6, $urandom(), $urandom(), 16'd7, 16'd8, 16'd90, 3, 0, 1);
    send_pkt(16'h0800, 8'd6, $urandom(), $urandom(), 16'd9, 16'd10, 16'd91, 2, 1, 1);
    drain_and_check("enable");
    check("enable_pkt_seen_one", RW'(pkt_seen), RW'(1));
    check("enable_len_b", RW'(write_data[47:32]), RW'(16'd91));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
